// File: rtl/rr_mux_arb.sv
// rr_mux_arb
//   Round-robin arbiter/sequencer sharing one registered output channel among
//   NUMIN valid/ready requesters. A lane holds the grant for up to MAXBURST
//   beats; the grant is dropped early if the lane goes idle. Backpressure
//   freezes the output register and the burst counter.
//
//   State  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | no grant; searching ptr, ptr+1, ... for the next valid lane
//   GRANT  | lane sel owns the output channel for the current burst
//
// Ports
//   clk       clock, rising edge
//   rst       asynchronous reset, active-high
//   din_vec   packed lane data, lane i at [i*DWIDTH +: DWIDTH]
//   din_v     per-lane valid
//   din_rdy   per-lane ready (combinational, at most one bit high)
//   dout      registered output data
//   dout_v    registered output valid
//   dout_rdy  downstream ready
//   sel       currently or most recently granted lane
//   busy      high while a grant is held
module rr_mux_arb #(
  parameter int NUMIN    = 16,
  parameter int DWIDTH   = 8,
  parameter int MAXBURST = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUMIN*DWIDTH-1:0]   din_vec,
  input  logic [NUMIN-1:0]          din_v,
  output logic [NUMIN-1:0]          din_rdy,
  output logic [DWIDTH-1:0]         dout,
  output logic                      dout_v,
  input  logic                      dout_rdy,
  output logic [$clog2(NUMIN)-1:0]  sel,
  output logic                      busy
);

  localparam int SW = $clog2(NUMIN);
  localparam int CW = (MAXBURST > 1) ? $clog2(MAXBURST) : 1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [SW-1:0]     r_ptr, w_ptr_nxt;
  logic [SW-1:0]     r_sel, w_sel_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic              r_busy;
  logic [DWIDTH-1:0] r_dout;
  logic              r_dout_v;

  logic              w_any;
  logic [SW-1:0]     w_pick;
  logic              w_out_free;
  logic              w_grant_rdy;
  logic              w_sel_v;
  logic              w_beat;
  logic [DWIDTH-1:0] w_sel_data;
  logic [SW-1:0]     w_sel_inc;

  // Rotating priority search. Offsets are scanned from the far end down so
  // the smallest offset from r_ptr is the last (winning) assignment. The
  // sum is one bit wider so the modulo works for non-power-of-2 NUMIN.
  always_comb begin
    logic [SW:0] w_sum;
    w_any  = 1'b0;
    w_pick = r_ptr;
    w_sum  = '0;
    for (int k = NUMIN - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_ptr} + (SW+1)'(k);
      if (w_sum >= (SW+1)'(NUMIN)) begin
        w_sum = w_sum - (SW+1)'(NUMIN);
      end
      if (din_v[w_sum[SW-1:0]]) begin
        w_any  = 1'b1;
        w_pick = w_sum[SW-1:0];
      end
    end
  end

  // Selected-lane mux for data and valid.
  always_comb begin
    w_sel_data = '0;
    w_sel_v    = 1'b0;
    for (int i = 0; i < NUMIN; i++) begin
      if (r_sel == SW'(i)) begin
        w_sel_data = din_vec[i*DWIDTH +: DWIDTH];
        w_sel_v    = din_v[i];
      end
    end
  end

  assign w_out_free  = !r_dout_v || dout_rdy;
  // Ready deliberately ignores din_v so no combinational valid->ready path.
  assign w_grant_rdy = (r_state == S_GRANT) && w_out_free;
  assign w_beat      = w_grant_rdy && w_sel_v;
  assign w_sel_inc   = (r_sel == SW'(NUMIN - 1)) ? '0 : r_sel + SW'(1);

  always_comb begin
    din_rdy = '0;
    for (int i = 0; i < NUMIN; i++) begin
      din_rdy[i] = w_grant_rdy && (r_sel == SW'(i));
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_sel_nxt   = r_sel;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt = S_GRANT;
          w_sel_nxt   = w_pick;
          w_cnt_nxt   = '0;
        end
      end
      S_GRANT: begin
        if (!w_sel_v) begin
          w_state_nxt = S_IDLE;
          w_ptr_nxt   = w_sel_inc;
          w_cnt_nxt   = '0;
        end else if (w_beat) begin
          if (r_cnt == CW'(MAXBURST - 1)) begin
            w_state_nxt = S_IDLE;
            w_ptr_nxt   = w_sel_inc;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_sel   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_sel   <= w_sel_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt == S_GRANT);
    end
  end

  // Output register; dout keeps its last value once drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout   <= '0;
      r_dout_v <= 1'b0;
    end else if (w_beat) begin
      r_dout   <= w_sel_data;
      r_dout_v <= 1'b1;
    end else if (dout_rdy) begin
      r_dout_v <= 1'b0;
    end
  end

  assign dout   = r_dout;
  assign dout_v = r_dout_v;
  assign sel    = r_sel;
  assign busy   = r_busy;

endmodule

// File: tb/tb_rr_mux_arb.sv
// Directed bench for rr_mux_arb.
//   u_a: NUMIN=16, MAXBURST=4  (streaming, backpressure, early release, reset)
//   u_b: NUMIN=16, MAXBURST=2  (fairness across lanes 0, 3, 15)
//   u_c: NUMIN=5,  MAXBURST=1  (non-power-of-2 wrap)
// Lane data on u_a is {lane, beat index}; on u_b/u_c it is the lane number,
// so the output stream directly shows the grant order.
module tb_rr_mux_arb;

  logic clk;
  logic rst;

  // u_a
  logic [16*8-1:0] din_vec_a;
  logic [15:0]     din_v_a, din_rdy_a;
  logic [7:0]      dout_a;
  logic            dout_v_a, dout_rdy_a;
  logic [3:0]      sel_a;
  logic            busy_a;
  // u_b
  logic [16*8-1:0] din_vec_b;
  logic [15:0]     din_v_b, din_rdy_b;
  logic [7:0]      dout_b;
  logic            dout_v_b, dout_rdy_b;
  logic [3:0]      sel_b;
  logic            busy_b;
  // u_c
  logic [5*8-1:0]  din_vec_c;
  logic [4:0]      din_v_c, din_rdy_c;
  logic [7:0]      dout_c;
  logic            dout_v_c, dout_rdy_c;
  logic [2:0]      sel_c;
  logic            busy_c;

  int n_vec = 0;
  int n_err = 0;

  logic [3:0]  seq_a [16];
  logic [15:0] hs_a;
  logic [7:0]  q_a [$];
  logic [7:0]  q_b [$];
  logic [7:0]  q_c [$];
  logic        rdy_bad;
  logic        sel_c_bad;

  rr_mux_arb #(.NUMIN(16), .DWIDTH(8), .MAXBURST(4)) u_a (
    .clk(clk), .rst(rst), .din_vec(din_vec_a), .din_v(din_v_a), .din_rdy(din_rdy_a),
    .dout(dout_a), .dout_v(dout_v_a), .dout_rdy(dout_rdy_a), .sel(sel_a), .busy(busy_a));

  rr_mux_arb #(.NUMIN(16), .DWIDTH(8), .MAXBURST(2)) u_b (
    .clk(clk), .rst(rst), .din_vec(din_vec_b), .din_v(din_v_b), .din_rdy(din_rdy_b),
    .dout(dout_b), .dout_v(dout_v_b), .dout_rdy(dout_rdy_b), .sel(sel_b), .busy(busy_b));

  rr_mux_arb #(.NUMIN(5), .DWIDTH(8), .MAXBURST(1)) u_c (
    .clk(clk), .rst(rst), .din_vec(din_vec_c), .din_v(din_v_c), .din_rdy(din_rdy_c),
    .dout(dout_c), .dout_v(dout_v_c), .dout_rdy(dout_rdy_c), .sel(sel_c), .busy(busy_c));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    din_vec_a = '0;
    din_vec_b = '0;
    din_vec_c = '0;
    for (int i = 0; i < 16; i++) begin
      din_vec_a[i*8 +: 8] = {4'(i), seq_a[i]};
      din_vec_b[i*8 +: 8] = 8'(i);
    end
    for (int i = 0; i < 5; i++) begin
      din_vec_c[i*8 +: 8] = 8'(i);
    end
  end

  // Inputs only change just after a rising edge, so the negedge view is
  // what the next rising edge will act on.
  always @(negedge clk) begin
    hs_a = din_v_a & din_rdy_a;
    if (dout_v_a && dout_rdy_a) q_a.push_back(dout_a);
    if (dout_v_b && dout_rdy_b) q_b.push_back(dout_b);
    if (dout_v_c && dout_rdy_c) q_c.push_back(dout_c);
    if (!$onehot0(din_rdy_a) || !$onehot0(din_rdy_b) || !$onehot0(din_rdy_c)) rdy_bad = 1'b1;
    if (sel_c > 3'd4) sel_c_bad = 1'b1;
  end

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 16; i++) begin
      if (hs_a[i]) seq_a[i] = seq_a[i] + 4'd1;
    end
    hs_a = '0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_b [10] = '{8'd0, 8'd0, 8'd3, 8'd3, 8'd15, 8'd15, 8'd0, 8'd0, 8'd3, 8'd3};
  logic [7:0] exp_c [8]  = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd1, 8'd2};

  initial begin
    rst = 1'b0;
    din_v_a = '0; din_v_b = '0; din_v_c = '0;
    dout_rdy_a = 1'b1; dout_rdy_b = 1'b1; dout_rdy_c = 1'b1;
    hs_a = '0; rdy_bad = 1'b0; sel_c_bad = 1'b0;
    for (int i = 0; i < 16; i++) seq_a[i] = '0;
    #1 rst = 1'b1;
    #1;
    chk("rst_dout",   32'(dout_a),    32'h0);
    chk("rst_dout_v", 32'(dout_v_a),  32'h0);
    chk("rst_sel",    32'(sel_a),     32'h0);
    chk("rst_busy",   32'(busy_a),    32'h0);
    chk("rst_rdy",    32'(din_rdy_a), 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    tick();

    // Single lane 5 streaming: 50..53, one idle cycle, 54..57
    din_v_a = 16'h0020;
    tick();
    chk("s_sel",    32'(sel_a),     32'h5);
    chk("s_busy",   32'(busy_a),    32'h1);
    chk("s_rdy",    32'(din_rdy_a), 32'h0020);
    chk("s_dv0",    32'(dout_v_a),  32'h0);
    tick();
    chk("s_d50",    32'(dout_a),    32'h50);
    chk("s_dv1",    32'(dout_v_a),  32'h1);
    tick(3);
    chk("s_d53",    32'(dout_a),    32'h53);
    chk("s_rel1",   32'(busy_a),    32'h0);
    tick();
    chk("s_gap",    32'(dout_v_a),  32'h0);
    chk("s_regr",   32'(busy_a),    32'h1);
    chk("s_sel2",   32'(sel_a),     32'h5);
    tick(4);
    chk("s_d57",    32'(dout_a),    32'h57);
    chk("s_rel2",   32'(busy_a),    32'h0);
    din_v_a = '0;
    tick();
    chk("s_drain",  32'(dout_v_a),  32'h0);
    chk("s_qlen",   32'(q_a.size()), 32'd8);
    for (int k = 0; k < 8; k++) chk("s_stream", 32'(q_a[k]), 32'h50 + 32'(k));
    q_a.delete();

    // Backpressure on lane 2 (search wraps from ptr=6)
    din_v_a = 16'h0004;
    tick();
    chk("b_sel",    32'(sel_a),     32'h2);
    tick();
    chk("b_d20",    32'(dout_a),    32'h20);
    tick();
    chk("b_d21",    32'(dout_a),    32'h21);
    dout_rdy_a = 1'b0;
    #1;
    chk("b_rdy0",   32'(din_rdy_a), 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("b_hold_d",  32'(dout_a),    32'h21);
      chk("b_hold_v",  32'(dout_v_a),  32'h1);
      chk("b_hold_r",  32'(din_rdy_a), 32'h0);
      chk("b_hold_bz", 32'(busy_a),    32'h1);
    end
    dout_rdy_a = 1'b1;
    tick();
    chk("b_d22",    32'(dout_a),    32'h22);
    chk("b_busy",   32'(busy_a),    32'h1);
    tick();
    chk("b_d23",    32'(dout_a),    32'h23);
    chk("b_rel",    32'(busy_a),    32'h0);
    din_v_a = '0;
    tick();
    chk("b_qlen",   32'(q_a.size()), 32'd4);
    for (int k = 0; k < 4; k++) chk("b_stream", 32'(q_a[k]), 32'h20 + 32'(k));
    q_a.delete();

    // Early release: lane 7 goes idle after one beat, ptr must move to 8
    din_v_a = 16'h0181;
    tick();
    chk("e_sel7",   32'(sel_a),     32'h7);
    tick();
    chk("e_d70",    32'(dout_a),    32'h70);
    din_v_a = 16'h0101;
    #1;
    chk("e_rdy_nov", 32'(din_rdy_a), 32'h0080);
    tick();
    chk("e_rel",    32'(busy_a),    32'h0);
    chk("e_dv",     32'(dout_v_a),  32'h0);
    tick();
    chk("e_sel8",   32'(sel_a),     32'h8);
    chk("e_busy",   32'(busy_a),    32'h1);
    din_v_a = '0;
    tick(2);
    chk("e_qlen",   32'(q_a.size()), 32'd1);
    chk("e_q0",     32'(q_a[0]),    32'h70);

    // Asynchronous reset in the middle of a burst
    din_v_a = 16'h0020;
    tick();
    chk("r_sel5",   32'(sel_a),     32'h5);
    tick();
    chk("r_d58",    32'(dout_a),    32'h58);
    #2 rst = 1'b1;
    #1;
    chk("r_dout",   32'(dout_a),    32'h0);
    chk("r_dv",     32'(dout_v_a),  32'h0);
    chk("r_sel",    32'(sel_a),     32'h0);
    chk("r_busy",   32'(busy_a),    32'h0);
    chk("r_rdy",    32'(din_rdy_a), 32'h0);
    din_v_a = 16'h1001;
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("r_prio0",  32'(sel_a),     32'h0);
    chk("r_pbusy",  32'(busy_a),    32'h1);
    din_v_a = '0;
    tick(3);

    // Fairness (u_b) and non-power-of-2 wrap (u_c) run side by side
    din_v_b = 16'h8009;
    din_v_c = 5'h1f;
    tick(16);
    din_v_b = '0;
    din_v_c = '0;
    tick(3);
    chk("f_qlen",   32'(q_b.size()), 32'd10);
    for (int k = 0; k < 10; k++) chk("f_order", 32'(q_b[k]), 32'(exp_b[k]));
    chk("c_qlen",   32'(q_c.size()), 32'd8);
    for (int k = 0; k < 8; k++) chk("c_order", 32'(q_c[k]), 32'(exp_c[k]));
    chk("c_sel_rng", 32'(sel_c_bad), 32'h0);
    chk("rdy_onehot", 32'(rdy_bad), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rr_mux_arb.md
# rr_mux_arb

Round-robin arbiter and sequencer that shares one registered DWIDTH-bit output channel among NUMIN valid/ready requesters. It selects one requester at a time and holds the grant for a burst of up to MAXBURST beats. It drives the selected lane's data through a single output register with backpressure. It sits in front of downstream consumers that previously took a statically selected mux output, and replaces the externally driven select with fair, handshake-driven scheduling.

## Interface
- NUMIN, default 16: number of requester lanes (≥2; need not be a power of 2).
- DWIDTH, default 8: data width per lane.
- MAXBURST, default 4: maximum beats transferred per grant (≥1).
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- din_vec  in  NUMIN*DWIDTH  packed lane data; lane i occupies bits [i*DWIDTH +: DWIDTH].
- din_v  in  NUMIN  per-lane valid.
- din_rdy  out  NUMIN  per-lane ready (combinational); at most one bit high.
- dout  out  DWIDTH  registered output data.
- dout_v  out  1  registered output valid.
- dout_rdy  in  1  downstream ready.
- sel  out  $clog2(NUMIN)  currently or most recently granted lane (registered).
- busy  out  1  registered; high while state is GRANT.

## Operation
- States: IDLE, GRANT. Internal regs: ptr (next-priority lane), cnt (beats in current grant, 0..MAXBURST-1).
- Reset values: state=IDLE, ptr=0, cnt=0, sel=0, busy=0, dout=0, dout_v=0. din_rdy decodes to all-zero.
- IDLE: if any din_v is set, grant the first lane with din_v=1 searching ptr, ptr+1, … modulo NUMIN. On grant: sel←that lane, cnt←0, state←GRANT. If no din_v is set, remain in IDLE and leave sel unchanged.
- out_free = !dout_v || dout_rdy.
- din_rdy[sel] = (state==GRANT) && out_free. All other din_rdy bits are 0.
- Beat transfer (GRANT, din_v[sel] && din_rdy[sel]): dout←din_vec[sel*DWIDTH +: DWIDTH], dout_v←1, cnt←cnt+1.
- Else if dout_rdy: dout_v←0. dout holds its last value.
- Grant release, GRANT→IDLE with ptr←(sel+1) mod NUMIN, cnt←0, under either condition:
  - a beat transfers while cnt==MAXBURST-1 (burst complete);
  - din_v[sel]==0 in GRANT (requester idle; no beat that cycle).
- Backpressure (din_v[sel]=1, out_free=0): stay in GRANT and do not count; the grant is not released.
- ptr wraps NUMIN-1→0. With non-power-of-2 NUMIN, sel never exceeds NUMIN-1.
- Asynchronous reset mid-burst: all registers return to reset values immediately. The pending dout beat is discarded.

## Timing
- Arbitration latency: din_v rises in cycle t while IDLE → GRANT/sel/busy valid in t+1 → din_rdy high in t+1 if out_free → dout_v high in t+2.
- Streaming: back-to-back beats from one lane at 1 beat/cycle while dout_rdy=1.
- Grant switch cost: 1 IDLE cycle between grants. Peak throughput is MAXBURST/(MAXBURST+1).
- Output register: dout/dout_v hold stable while dout_v=1 and dout_rdy=0.
- din_rdy depends combinationally on state, sel, dout_v and dout_rdy only, never on din_v.

## Test plan
- Reset: assert rst mid-burst → dout=0, dout_v=0, sel=0, busy=0, din_rdy=0 asynchronously. After release, lane 0 is highest priority.
- Single lane, NUMIN=16, MAXBURST=4: lane 5 continuously valid with data 0x50,0x51,… and dout_rdy=1 → dout sequence 0x50..0x53, 1 idle cycle, then 0x54..0x57. sel=5 throughout.
- Fairness: lanes 0, 3 and 15 always valid, MAXBURST=2 → grant order 0,3,15,0,3,… with 2 beats each; ptr wraps 15→0.
- Backpressure: lane 2 streaming, dout_rdy=0 for 3 cycles → dout/dout_v frozen, din_rdy[2]=0, cnt unchanged. Each beat appears exactly once and no beat is lost or duplicated.
- Early release: lane 7 drops din_v after 1 beat, MAXBURST=4 → grant releases with ptr=8; pending lane 8 is granted next.
- NUMIN=5, MAXBURST=1: all lanes valid → sel cycles 0,1,2,3,4,0 with one beat each and never reaches 5–7.
